// File: rtl/fmap_bank_pingpong.sv
// Double-buffered feature-map store: NUM_BANKS parallel banks, two pages (write page_sel, read ~page_sel),
// masked writes, registered range-checked reads and a sequential clear sweep in place of array reset.
module fmap_bank_pingpong #(
  parameter int NUM_BANKS = 64,
  parameter int DATA_W    = 16,
  parameter int DEPTH     = 12321,
  parameter int ADDR_W    = 14
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        swap,
  input  logic                        clear_start,
  output logic                        busy,
  output logic                        page_sel,
  input  logic                        wr_en,
  input  logic [ADDR_W-1:0]           wr_addr,
  input  logic [NUM_BANKS-1:0]        wr_mask,
  input  logic [NUM_BANKS*DATA_W-1:0] wr_data,
  output logic                        wr_err,
  input  logic                        rd_en,
  input  logic [ADDR_W-1:0]           rd_addr,
  output logic                        rd_valid,
  output logic [NUM_BANKS*DATA_W-1:0] rd_data,
  output logic                        rd_err
);

  typedef enum logic [1:0] {IDLE = 2'd0, CLR_ALL = 2'd1, CLR_PAGE = 2'd2} state_t;

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_t            state_r, state_s;
  logic [ADDR_W-1:0] cnt_r, cnt_s;
  logic              busy_r;
  logic              page_r;
  logic              rd_valid_r, rd_err_r, wr_err_r;
  logic [NUM_BANKS*DATA_W-1:0] rd_data_r;

  logic              idle_s, clr_s;
  logic              wr_ok_s, wr_bad_s, rd_fire_s, rd_ok_s;
  logic [IDX_W-1:0]  waddr_s, raddr_s;
  logic [DATA_W-1:0] rd_word_s [2][NUM_BANKS];

  // Full-width compares: wide out-of-range addresses must never alias onto a legal word.
  assign idle_s    = (state_r == IDLE);
  assign clr_s     = (state_r != IDLE);
  assign wr_ok_s   = idle_s & wr_en & (wr_addr <= LAST);
  assign wr_bad_s  = idle_s & wr_en & (wr_addr > LAST);
  assign rd_fire_s = idle_s & rd_en;
  assign rd_ok_s   = (rd_addr <= LAST);
  assign waddr_s   = clr_s ? cnt_r[IDX_W-1:0] : wr_addr[IDX_W-1:0];
  assign raddr_s   = rd_addr[IDX_W-1:0];

  // Sweep FSM next-state logic
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (clear_start) begin
          state_s = CLR_PAGE;
          cnt_s   = {ADDR_W{1'b0}};
        end else begin
          state_s = IDLE;
        end
      end
      CLR_ALL, CLR_PAGE: begin
        if (cnt_r == LAST) begin
          state_s = IDLE;
          cnt_s   = {ADDR_W{1'b0}};
        end else begin
          cnt_s = cnt_r + ADDR_W'(1);
        end
      end
      default: begin
        state_s = CLR_ALL;
        cnt_s   = {ADDR_W{1'b0}};
      end
    endcase
  end

  // Sweep state, busy flag and page select registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= CLR_ALL;
      cnt_r   <= {ADDR_W{1'b0}};
      busy_r  <= 1'b1;
      page_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      busy_r  <= (state_s != IDLE);
      if (idle_s && swap) begin
        page_r <= ~page_r;
      end else begin
        page_r <= page_r;
      end
    end
  end

  // One single-write-port RAM per page per bank so CLR_ALL can zero both pages at once.
  for (genvar p = 0; p < 2; p++) begin : g_page
    localparam logic PG = 1'(p);
    for (genvar k = 0; k < NUM_BANKS; k++) begin : g_bank
      logic [DATA_W-1:0] mem [0:DEPTH-1];
      logic              we_s;

      // Write enable: sweep or masked write into the current write page
      always_comb begin
        we_s = 1'b0;
        if (clr_s) begin
          we_s = (state_r == CLR_ALL) || (page_r == PG);
        end else begin
          we_s = wr_ok_s && wr_mask[k] && (page_r == PG);
        end
      end

      // Bank storage write port
      always_ff @(posedge clk) begin
        if (we_s) begin
          mem[waddr_s] <= clr_s ? {DATA_W{1'b0}} : wr_data[k*DATA_W +: DATA_W];
        end
      end

      assign rd_word_s[p][k] = mem[raddr_s];
    end
  end

  // Registered read response and error pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_r <= 1'b0;
      rd_err_r   <= 1'b0;
      wr_err_r   <= 1'b0;
      rd_data_r  <= {(NUM_BANKS*DATA_W){1'b0}};
    end else begin
      rd_valid_r <= rd_fire_s;
      rd_err_r   <= rd_fire_s & ~rd_ok_s;
      wr_err_r   <= wr_bad_s;
      if (rd_fire_s) begin
        for (int k = 0; k < NUM_BANKS; k++) begin
          rd_data_r[k*DATA_W +: DATA_W] <= rd_ok_s ? rd_word_s[~page_r][k] : {DATA_W{1'b0}};
        end
      end else begin
        rd_data_r <= rd_data_r;
      end
    end
  end

  assign busy     = busy_r;
  assign page_sel = page_r;
  assign rd_valid = rd_valid_r;
  assign rd_err   = rd_err_r;
  assign wr_err   = wr_err_r;
  assign rd_data  = rd_data_r;

endmodule
